ctrl_pipe: RTL and testbench



---
 rtl/ctrl_pipe.sv | 136 +++++++++++++
 tb/tb_ctrl_pipe.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// Pipeline control-word carrier (ID/EX, EX/MEM, MEM/WB) with load-use stall, forwarding and branch flush.
// Optional stall/flush statistics counters enabled by defining CTRL_PIPE_STATS_EN.
module ctrl_pipe #(
  parameter int REG_W = 5,
  parameter int CW    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CW-1:0]    ctr_bits,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             mem_zero,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             pc_src,
  output logic             ex_reg_dst,
  output logic             ex_alu_src,
  output logic [1:0]       ex_alu_op,
  output logic [REG_W-1:0] ex_rs,
  output logic [REG_W-1:0] ex_rt,
  output logic [REG_W-1:0] ex_dest,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_branch,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic [REG_W-1:0] mem_dest,
  output logic             wb_reg_write,
  output logic             wb_mem_to_reg,
  output logic [REG_W-1:0] wb_dest
`ifdef CTRL_PIPE_STATS_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt
`endif
);

  logic [CW-1:0]    r_idex_ctl;
  logic [REG_W-1:0] r_ex_rs, r_ex_rt, r_ex_rd;
  // {Branch, MemRead, MemWrite, RegWrite, MemtoReg}
  logic [4:0]       r_exmem_ctl;
  logic [REG_W-1:0] r_mem_dest;
  // {RegWrite, MemtoReg}
  logic [1:0]       r_memwb_ctl;
  logic [REG_W-1:0] r_wb_dest;

  logic             w_stall;
  logic             w_taken;
  logic [REG_W-1:0] w_ex_dest;

  assign w_ex_dest = r_idex_ctl[8] ? r_ex_rd : r_ex_rt;
  assign w_stall   = r_idex_ctl[3] && (r_ex_rt != '0) &&
                     ((r_ex_rt == id_rs) || (r_ex_rt == id_rt));
  assign w_taken   = r_exmem_ctl[4] & mem_zero;

  // A taken branch overrides the stall: the flush already discards the dependent instruction.
  assign pc_write    = ~w_stall | w_taken;
  assign if_id_write = ~w_stall | w_taken;
  assign if_id_flush = w_taken;
  assign pc_src      = w_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idex_ctl  <= '0;
      r_ex_rs     <= '0;
      r_ex_rt     <= '0;
      r_ex_rd     <= '0;
      r_exmem_ctl <= '0;
      r_mem_dest  <= '0;
      r_memwb_ctl <= '0;
      r_wb_dest   <= '0;
    end else begin
      r_idex_ctl  <= (w_stall || w_taken) ? '0 : ctr_bits;
      r_ex_rs     <= id_rs;
      r_ex_rt     <= id_rt;
      r_ex_rd     <= id_rd;
      r_exmem_ctl <= w_taken ? '0 : r_idex_ctl[4:0];
      r_mem_dest  <= w_ex_dest;
      r_memwb_ctl <= r_exmem_ctl[1:0];
      r_wb_dest   <= r_mem_dest;
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    if (r_exmem_ctl[1] && (r_mem_dest != '0) && (r_mem_dest == r_ex_rs))
      fwd_a = 2'b10;
    else if (r_memwb_ctl[1] && (r_wb_dest != '0) && (r_wb_dest == r_ex_rs))
      fwd_a = 2'b01;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (r_exmem_ctl[1] && (r_mem_dest != '0) && (r_mem_dest == r_ex_rt))
      fwd_b = 2'b10;
    else if (r_memwb_ctl[1] && (r_wb_dest != '0) && (r_wb_dest == r_ex_rt))
      fwd_b = 2'b01;
  end

  assign ex_reg_dst    = r_idex_ctl[8];
  assign ex_alu_op     = r_idex_ctl[7:6];
  assign ex_alu_src    = r_idex_ctl[5];
  assign ex_rs         = r_ex_rs;
  assign ex_rt         = r_ex_rt;
  assign ex_dest       = w_ex_dest;
  assign mem_branch    = r_exmem_ctl[4];
  assign mem_mem_read  = r_exmem_ctl[3];
  assign mem_mem_write = r_exmem_ctl[2];
  assign mem_dest      = r_mem_dest;
  assign wb_reg_write  = r_memwb_ctl[1];
  assign wb_mem_to_reg = r_memwb_ctl[0];
  assign wb_dest       = r_wb_dest;

`ifdef CTRL_PIPE_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && !w_taken && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_taken && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed self-checking bench for ctrl_pipe: reset, load-use, forwarding, branch flush, stats.
module tb_ctrl_pipe;

  localparam logic [8:0] NOP = 9'b000000000;
  localparam logic [8:0] RT  = 9'b110000010;
  localparam logic [8:0] LW  = 9'b000101011;
  localparam logic [8:0] BEQ = 9'b001010000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] ctr_bits;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       mem_zero;
  logic       pc_write, if_id_write, if_id_flush, pc_src;
  logic       ex_reg_dst, ex_alu_src;
  logic [1:0] ex_alu_op;
  logic [4:0] ex_rs, ex_rt, ex_dest;
  logic [1:0] fwd_a, fwd_b;
  logic       mem_branch, mem_mem_read, mem_mem_write;
  logic [4:0] mem_dest;
  logic       wb_reg_write, wb_mem_to_reg;
  logic [4:0] wb_dest;
`ifdef CTRL_PIPE_STATS_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ctrl_pipe #(.REG_W(5), .CW(9)) dut (
    .clk(clk), .rst(rst), .ctr_bits(ctr_bits),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .mem_zero(mem_zero),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush), .pc_src(pc_src),
    .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_branch(mem_branch), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_dest(mem_dest), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_dest(wb_dest)
`ifdef CTRL_PIPE_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  logic [33:0] stage_bus;
  assign stage_bus = {ex_reg_dst, ex_alu_src, ex_alu_op, ex_rs, ex_rt, ex_dest,
                      mem_branch, mem_mem_read, mem_mem_write, mem_dest,
                      wb_reg_write, wb_mem_to_reg, wb_dest};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [8:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd);
    ctr_bits = c;
    id_rs    = rs;
    id_rt    = rt;
    id_rd    = rd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    drive(NOP, 5'd0, 5'd0, 5'd0);
    mem_zero = 1'b0;
    #12;
    chk("rst_stage", 64'(stage_bus), 64'd0);
    chk("rst_pc_write", 64'(pc_write), 64'd1);
    chk("rst_if_id_write", 64'(if_id_write), 64'd1);
    chk("rst_flush_src", 64'({if_id_flush, pc_src}), 64'd0);
    chk("rst_fwd", 64'({fwd_a, fwd_b}), 64'd0);
    rst = 1'b0;

    // stream, then reset mid-flight with a load-use pending
    drive(RT, 5'd1, 5'd2, 5'd3); tick;
    drive(LW, 5'd1, 5'd5, 5'd0); tick;
    drive(RT, 5'd5, 5'd6, 5'd7); #1;
    chk("pre_rst_stall", 64'(pc_write), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_stage", 64'(stage_bus), 64'd0);
    chk("midrst_hazard", 64'({pc_write, if_id_write, if_id_flush, pc_src, fwd_a, fwd_b}), 64'b1100_0000);
    #2 rst = 1'b0;

    drive(RT, 5'd1, 5'd2, 5'd3); tick;
    chk("r_ex_ctl", 64'({ex_reg_dst, ex_alu_src, ex_alu_op}), 64'b1010);
    chk("r_ex_dest", 64'(ex_dest), 64'd3);
    drive(NOP, 5'd0, 5'd0, 5'd0); tick;
    chk("r_mem_dest", 64'(mem_dest), 64'd3);
    tick;
    chk("r_wb", 64'({wb_reg_write, wb_mem_to_reg, wb_dest}), 64'b1_0_00011);

    // load-use
    drive(LW, 5'd1, 5'd5, 5'd0); tick;
    chk("lu_ex_dest", 64'(ex_dest), 64'd5);
    drive(RT, 5'd5, 5'd6, 5'd7); #1;
    chk("lu_stall", 64'({pc_write, if_id_write}), 64'b00);
    tick;
    chk("lu_bubble_ex", 64'({ex_reg_dst, ex_alu_src, ex_alu_op}), 64'd0);
    chk("lu_fields", 64'({ex_rs, ex_rt}), 64'({5'd5, 5'd6}));
    chk("lu_lw_mem", 64'({mem_mem_read, mem_dest}), 64'({1'b1, 5'd5}));
    chk("lu_release", 64'({pc_write, if_id_write}), 64'b11);
    tick;
    chk("lu_bubble_mem", 64'({mem_branch, mem_mem_read, mem_mem_write}), 64'd0);
    chk("lu_add_ex", 64'({ex_reg_dst, ex_alu_op, ex_rs}), 64'({1'b1, 2'b10, 5'd5}));
    chk("lu_wb", 64'({wb_reg_write, wb_mem_to_reg, wb_dest}), 64'b1_1_00101);
    chk("lu_fwd", 64'({fwd_a, fwd_b}), 64'b0100);

    // forwarding priority and register 0
    drive(RT, 5'd1, 5'd2, 5'd3); tick;
    drive(RT, 5'd1, 5'd2, 5'd3); tick;
    drive(RT, 5'd3, 5'd3, 5'd4); tick;
    chk("fw_priority", 64'({fwd_a, fwd_b}), 64'b1010);
    drive(RT, 5'd1, 5'd2, 5'd0); tick;
    drive(RT, 5'd1, 5'd2, 5'd0); tick;
    drive(RT, 5'd0, 5'd0, 5'd4); tick;
    chk("fw_zero", 64'({fwd_a, fwd_b}), 64'd0);
    chk("fw_zero_dest", 64'({mem_dest, wb_dest, wb_reg_write}), 64'b00000_00000_1);

    // taken branch
    drive(BEQ, 5'd1, 5'd2, 5'd0); tick;
    drive(RT, 5'd8, 5'd9, 5'd10); tick;
    drive(RT, 5'd8, 5'd9, 5'd11); mem_zero = 1'b1; #1;
    chk("br_taken", 64'({pc_src, if_id_flush, mem_branch, pc_write}), 64'b1111);
    tick;
    mem_zero = 1'b0;
    drive(NOP, 5'd0, 5'd0, 5'd0); #1;
    chk("br_ex_flush", 64'({ex_reg_dst, ex_alu_src, ex_alu_op}), 64'd0);
    chk("br_mem_flush", 64'({mem_branch, mem_mem_read, mem_mem_write}), 64'd0);
    chk("br_after", 64'({pc_src, if_id_flush}), 64'd0);

    // not-taken branch
    drive(BEQ, 5'd1, 5'd2, 5'd0); tick;
    drive(RT, 5'd8, 5'd9, 5'd12); tick;
    drive(NOP, 5'd0, 5'd0, 5'd0); #1;
    chk("br_nt", 64'({pc_src, if_id_flush, mem_branch}), 64'b001);
    tick;
    chk("br_nt_mem", 64'({mem_dest, mem_branch}), 64'({5'd12, 1'b0}));
    tick;
    chk("br_nt_wb", 64'({wb_reg_write, wb_dest}), 64'({1'b1, 5'd12}));

    // taken branch coinciding with a load-use condition
    drive(BEQ, 5'd1, 5'd2, 5'd0); tick;
    drive(LW, 5'd1, 5'd5, 5'd0); tick;
    drive(RT, 5'd5, 5'd6, 5'd7); mem_zero = 1'b1; #1;
    chk("sim_no_stall", 64'({pc_write, if_id_write, pc_src, if_id_flush}), 64'b1111);
`ifdef CTRL_PIPE_STATS_EN
    chk("sim_cnt_before", 64'({stall_cnt, flush_cnt}), 64'({16'd1, 16'd1}));
`endif
    tick;
    mem_zero = 1'b0;
    drive(NOP, 5'd0, 5'd0, 5'd0); #1;
    chk("sim_flushed", 64'({ex_reg_dst, ex_alu_src, ex_alu_op, mem_branch, mem_mem_read, mem_mem_write}), 64'd0);
    chk("sim_pc_write", 64'(pc_write), 64'd1);
`ifdef CTRL_PIPE_STATS_EN
    chk("sim_cnt_after", 64'({stall_cnt, flush_cnt}), 64'({16'd1, 16'd2}));

    force dut.w_stall = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    release dut.w_stall;
    chk("stall_saturate", 64'(stall_cnt), 64'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
